// File: rtl/muldiv_unit_pkg.sv
// Shared constants and helpers for the HI/LO multiply/divide unit.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle MULT/MULTU).
package muldiv_unit_pkg;

    // Global stall vector layout; bit STALL_EX belongs to the EX stage.
    localparam int   STALL_W  = 6;
    localparam int   STALL_EX = 2;
    localparam logic STOP     = 1'b1;
    localparam logic NO_STOP  = 1'b0;

    // Unit FSM encodings.
    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_BUSY = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    // Number of shift-subtract / shift-add iterations.
    localparam int MD_ITER = 32;

    // Two's-complement negate when neg is set.
    function automatic logic [31:0] neg_if32(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg_if64(input logic neg, input logic [63:0] v);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Iterative engine: restoring divider on magnitudes, and the shift-add
// multiplier that shares its counter and registers. Sign correction is
// applied on the final iteration so results leave the core ready to write.
module muldiv_unit_div_core
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic        is_mul,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        done,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res
);

    logic        busy_q, busy_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] acc_hi_q, acc_hi_d;   // remainder / product high
    logic [31:0] acc_lo_q, acc_lo_d;   // quotient / multiplier shifting out
    logic [31:0] opnd_q, opnd_d;       // divisor / multiplicand magnitude
    logic        mul_q, mul_d;
    logic        neg_q_q, neg_q_d;     // negate quotient / product
    logic        neg_r_q, neg_r_d;     // negate remainder

    logic        sa, sb;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] diff;
    logic [32:0] sum;
    logic [31:0] hi_n, lo_n;
    logic [63:0] prod_fix;

    // One iteration of whichever operation is in flight, plus sign fix-up.
    always_comb begin
        sa     = is_signed & a[31];
        sb     = is_signed & b[31];
        a_mag  = neg_if32(sa, a);
        b_mag  = neg_if32(sb, b);

        rem_sh = {acc_hi_q, acc_lo_q[31]};
        ge     = (rem_sh >= {1'b0, opnd_q});
        diff   = rem_sh[31:0] - opnd_q;
        sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);

        if (mul_q) begin
            hi_n = sum[32:1];
            lo_n = {sum[0], acc_lo_q[31:1]};
        end else begin
            hi_n = ge ? diff : rem_sh[31:0];
            lo_n = {acc_lo_q[30:0], ge};
        end

        done     = busy_q && (cnt_q == 6'(MD_ITER - 1));
        prod_fix = neg_if64(neg_q_q, {hi_n, lo_n});
        hi_res   = mul_q ? prod_fix[63:32] : neg_if32(neg_r_q, hi_n);
        lo_res   = mul_q ? prod_fix[31:0]  : neg_if32(neg_q_q, lo_n);
    end

    // Next-state for the counter and working registers.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        mul_d    = mul_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        if (flush) begin
            busy_d = 1'b0;
            cnt_d  = 6'd0;
        end else if (start) begin
            busy_d   = 1'b1;
            cnt_d    = 6'd0;
            acc_hi_d = 32'd0;
            acc_lo_d = a_mag;
            opnd_d   = b_mag;
            mul_d    = is_mul;
            neg_q_d  = sa ^ sb;
            neg_r_d  = sa;
        end else if (busy_q) begin
            acc_hi_d = hi_n;
            acc_lo_d = lo_n;
            cnt_d    = cnt_q + 6'd1;
            if (done) busy_d = 1'b0;
        end
    end

    // Register update; reset discards any partial operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= 6'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            opnd_q   <= 32'd0;
            mul_q    <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            mul_q    <= mul_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage HI/LO write producer for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Iterative ops stall the pipe via stallreq and write once from DONE.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational MULT/MULTU.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               op_mult,
    input  logic               op_multu,
    input  logic               op_div,
    input  logic               op_divu,
    input  logic               op_mthi,
    input  logic               op_mtlo,
    input  logic [31:0]        src_a,
    input  logic [31:0]        src_b,
    output logic               stallreq,
    output logic               hi_we,
    output logic               lo_we,
    output logic [31:0]        hi_wdata,
    output logic [31:0]        lo_wdata
);

    logic [1:0]  state_q, state_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;

    logic        is_div, iter_op, op_signed, div_by_zero;
    logic        start, core_done;
    logic [31:0] core_hi, core_lo;
    logic        st_req, hwe, lwe;
    logic [31:0] hwd, lwd;
    logic        unused_stall;

    assign unused_stall = ^{stall[STALL_W-1:STALL_EX+1], stall[STALL_EX-1:0]};

    assign is_div      = op_div | op_divu;
    assign op_signed   = op_div | op_mult;
    assign div_by_zero = is_div && (src_b == 32'd0);

`ifdef MULDIV_FAST_MUL_EN
    logic        fast_mul;
    logic [63:0] fast_prod;
    assign iter_op   = is_div;
    assign fast_mul  = op_mult | op_multu;
    assign fast_prod = op_mult ? ({{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b})
                               : ({32'd0, src_a} * {32'd0, src_b});
`else
    assign iter_op   = is_div | op_mult | op_multu;
`endif

    muldiv_unit_div_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .is_mul    (~is_div),
        .is_signed (op_signed),
        .a         (src_a),
        .b         (src_b),
        .done      (core_done),
        .hi_res    (core_hi),
        .lo_res    (core_lo)
    );

    // FSM sequencing and EX-stage write bus generation.
    always_comb begin
        state_d  = state_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        start    = 1'b0;
        st_req   = 1'b0;
        hwe      = 1'b0;
        lwe      = 1'b0;
        hwd      = 32'd0;
        lwd      = 32'd0;
        if (flush) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (iter_op) begin
                        st_req = 1'b1;
                        if (div_by_zero) begin
                            res_hi_d = src_a;
                            res_lo_d = 32'hFFFF_FFFF;
                            state_d  = MD_DONE;
                        end else begin
                            start   = 1'b1;
                            state_d = MD_BUSY;
                        end
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (fast_mul) begin
                        hwe = 1'b1;
                        lwe = 1'b1;
                        hwd = fast_prod[63:32];
                        lwd = fast_prod[31:0];
                    end
`endif
                end
                MD_BUSY: begin
                    st_req = 1'b1;
                    if (core_done) begin
                        res_hi_d = core_hi;
                        res_lo_d = core_lo;
                        state_d  = MD_DONE;
                    end
                end
                MD_DONE: begin
                    hwe = 1'b1;
                    lwe = 1'b1;
                    hwd = res_hi_q;
                    lwd = res_lo_q;
                    if (stall[STALL_EX] == NO_STOP) state_d = MD_IDLE;
                end
                default: state_d = MD_IDLE;
            endcase
            // Moves to HI/LO bypass the FSM entirely.
            if (op_mthi) begin
                st_req = 1'b0;
                hwe    = 1'b1;
                hwd    = src_a;
                lwe    = 1'b0;
                lwd    = 32'd0;
            end else if (op_mtlo) begin
                st_req = 1'b0;
                lwe    = 1'b1;
                lwd    = src_a;
                hwe    = 1'b0;
                hwd    = 32'd0;
            end
        end
    end

    // Outputs are held at zero for as long as reset is asserted.
    assign stallreq = rst_n & st_req;
    assign hi_we    = rst_n & hwe;
    assign lo_we    = rst_n & lwe;
    assign hi_wdata = rst_n ? hwd : 32'd0;
    assign lo_wdata = rst_n ? lwd : 32'd0;

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Write-side producer for the HI/LO register pair: executes MULT/MULTU/DIV/DIVU/MTHI/MTLO in the EX stage. Drives the EX-stage HI/LO write-enable/data bus that feeds HI/LO forwarding and, down the pipe, the WB write bus. Division is iterative and stalls the pipeline through a stall request. Multiplication is single-cycle or iterative depending on configuration.

## Interface
Parameters: none. Widths are fixed at 32/64.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  `StallBus  global stall vector. Bit 2 = EX stage (`Stop`/`NoStop`).
- flush  in  1  cancel in-flight operation, no write
- op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo  in  1 each  EX decode, at most one high
- src_a  in  32  rs operand
- src_b  in  32  rt operand
- stallreq  out  1  EX stall request to the stall controller
- hi_we, lo_we  out  1  HI/LO write enables, EX-stage bus
- hi_wdata, lo_wdata  out  32  HI/LO write data

## Operation
- FSM states: IDLE, BUSY, DONE. Iteration counter cnt is 6 bits (0..32).
- MTHI: combinational in any state. Drives hi_we=1, hi_wdata=src_a, lo_we=0, stallreq=0. MTLO is the mirror case.
- DIV/DIVU in IDLE (flush=0):
  - stallreq=1 combinationally.
  - Latch |a| and |b| (raw values for DIVU) and the sign flags; cnt=0; go to BUSY.
- BUSY:
  - One restoring shift-subtract iteration per cycle; stallreq=1.
  - After iteration 32, apply signs: quotient is negated if sign(a)^sign(b); remainder takes sign(a). Go to DONE.
- Divide by zero is detected at IDLE and goes straight to DONE: LO=32'hFFFFFFFF, HI=src_a.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This needs no special case: the magnitude path produces it.
- DONE:
  - stallreq=0; hi_we=lo_we=1; hi_wdata=remainder (or product high); lo_wdata=quotient (or product low).
  - Go to IDLE when stall[2]==`NoStop`. Hold DONE, outputs stable, while stall[2]==`Stop`.
- Multiply: HI:LO = 64-bit product, signed for MULT, unsigned for MULTU. Mode is per Configuration.
- flush=1 in any state: stallreq=0 and we=0 that cycle; IDLE next edge; result registers not updated.
- No op asserted in IDLE: all outputs 0.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0, result/operand registers 0. All outputs forced 0 while rst_n is low.
- MTHI/MTLO: 0-cycle latency, no stall.
- Divide: op seen at cycle N, IDLE, stallreq=1. Cycles N+1..N+32 are BUSY, stallreq=1. Cycle N+33 is DONE with write. stallreq is high for exactly 33 cycles.
- Divide by zero: stallreq high at N only; DONE at N+1.
- The writes presented in DONE travel down the pipe with the instruction. The unit never writes twice for one instruction.
- An op asserted while already in DONE is the same instruction. It does not restart.
- Reset deasserted mid-operation: restart from IDLE. Any partial result is discarded.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU are combinational in IDLE: hi_we=lo_we=1 with the product in the same cycle, stallreq=0, FSM stays in IDLE.
- Not defined:
  - MULT/MULTU use the DIV flow: IDLE, 32 BUSY cycles of shift-add on magnitudes, sign fix, then DONE. stallreq is high for 33 cycles.
  - Multiply by zero still takes the full 33 cycles.

## Structure
- lib/defines.vh holds:
  - state encodings MD_IDLE/MD_BUSY/MD_DONE
  - MD_ITER = 32
  - existing `StallBus`, `Stop`, `NoStop`
- Sub-module: div_core. It owns the iterative restoring divider and its counter, with a start/done handshake and signed flag. The shift-add multiplier reuses its counter when fast multiply is compiled out.

## Test plan
- DIVU src_a=100, src_b=7: stallreq high 33 cycles, then hi_we=lo_we=1, LO=14, HI=2.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- MULT 0xFFFFFFFF*2: HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands: HI=0x1, LO=0xFFFFFFFE. Check 0 stall cycles with MULDIV_FAST_MUL_EN and 33 without.
- DIVU src_b=0, src_a=0x1234: DONE after 1 stall cycle, LO=0xFFFFFFFF, HI=0x1234.
- DIV with flush at BUSY cycle 10: no hi_we/lo_we, IDLE next cycle. A following MTLO 0x55 gives lo_we=1, lo_wdata=0x55 immediately.
- Hold stall[2]=`Stop` for 3 cycles in DONE: write outputs stable all 3 cycles, then IDLE. Assert rst_n=0 mid-BUSY: all outputs 0 asynchronously.
